// File: rtl/dual_slope_pkg.sv
// Shared types and defaults for the dual-slope ADC slice.
// Holds FSM state enum and default WIDTH/N_INT constants.
package dual_slope_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int N_INT_DEF = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INT,
    ST_DEINT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dual_slope_counter_if.sv
// Sequencer <-> counter bundle for the dual-slope ADC.
// master = sequencer side, slave = counter/result datapath.
interface dual_slope_counter_if
  import dual_slope_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             clear;
  logic             enable_counting;
  logic             load;
  logic             finished_counting;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic             seq_error;

  modport master (
    output clear,
    output enable_counting,
    output load,
    input  finished_counting,
    input  result,
    input  result_valid,
    input  overflow,
    input  seq_error
  );

  modport slave (
    input  clear,
    input  enable_counting,
    input  load,
    output finished_counting,
    output result,
    output result_valid,
    output overflow,
    output seq_error
  );

endinterface

// File: rtl/sat_counter.sv
// WIDTH-bit counter: sync clear, enable, saturation, sticky sat.
// Ports: clk, rst_n, clr, inc -> count, sat.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      // Increment past MAX is swallowed and flagged.
      if (count == MAX) sat <= 1'b1;
      else count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dual_slope_counter.sv
// Dual-slope ADC counter: integrate, de-integrate, latch result.
// Ports: clk, rst_n, bus (slave: clear/enable/load in, status out).
module dual_slope_counter
  import dual_slope_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_INT = N_INT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_slope_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(N_INT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count;
  logic             sat;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             term_hit;
  logic             accept_load;
  logic             bad_load;

  logic             fin_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             ovf_q;
  logic             err_q;

  sat_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(count),
    .sat  (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_clr     = bus.clear;
    cnt_inc     = 1'b0;
    term_hit    = 1'b0;
    accept_load = 1'b0;
    bad_load    = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          bad_load = bus.load;
          if (bus.enable_counting) begin
            cnt_inc = 1'b1;
            state_d = ST_INT;
          end
        end
        ST_INT: begin
          bad_load = bus.load;
          if (bus.enable_counting) begin
            // Terminal edge reuses the counter for de-integrate.
            if (count == TERM) begin
              term_hit = 1'b1;
              cnt_clr  = 1'b1;
              state_d  = ST_DEINT;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ST_DEINT: begin
          if (bus.load) begin
            accept_load = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cnt_inc = bus.enable_counting;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= accept_load;
      if (accept_load) begin
        result_q <= count;
        ovf_q    <= sat;
      end
      if (bus.clear) begin
        fin_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (term_hit) fin_q <= 1'b1;
        if (bad_load) err_q <= 1'b1;
      end
    end
  end

  assign bus.finished_counting = fin_q;
  assign bus.result            = result_q;
  assign bus.result_valid      = valid_q;
  assign bus.overflow          = ovf_q;
  assign bus.seq_error         = err_q;

endmodule

// File: tb/tb_dual_slope_counter.sv
// Directed bench for dual_slope_counter (WIDTH=8, N_INT=10).
// Linear steps; immediate assertions with hand-computed values.
module tb_dual_slope_counter;

  localparam int W = 8;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dual_slope_counter_if #(.WIDTH(W)) bus ();

  dual_slope_counter #(
    .WIDTH(W),
    .N_INT(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic c, input logic e,
                     input logic l);
    bus.clear           = c;
    bus.enable_counting = e;
    bus.load            = l;
  endtask

  initial begin
    drv(0, 0, 0);
    rst_n = 1'b0;
    tick(2);
    chk("rst_fin", 32'(bus.finished_counting), 0);
    chk("rst_res", 32'(bus.result), 0);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_err", 32'(bus.seq_error), 0);
    rst_n = 1'b1;
    tick();

    // 1: nominal, load together with enable
    drv(0, 1, 0);
    tick(9);
    chk("t1_fin9", 32'(bus.finished_counting), 0);
    tick();
    chk("t1_fin10", 32'(bus.finished_counting), 1);
    tick(37);
    drv(0, 1, 1);
    tick();
    chk("t1_res", 32'(bus.result), 37);
    chk("t1_rv", 32'(bus.result_valid), 1);
    chk("t1_ovf", 32'(bus.overflow), 0);
    drv(0, 0, 0);
    tick();
    chk("t1_rv_off", 32'(bus.result_valid), 0);
    chk("t1_fin_hold", 32'(bus.finished_counting), 1);
    drv(0, 1, 1);
    tick();
    chk("done_rv", 32'(bus.result_valid), 0);
    chk("done_err", 32'(bus.seq_error), 0);
    chk("done_res", 32'(bus.result), 37);

    // 2: overflow then clean conversion
    drv(1, 0, 0);
    tick();
    chk("t2_clr_fin", 32'(bus.finished_counting), 0);
    chk("t2_clr_res", 32'(bus.result), 37);
    drv(0, 1, 0);
    tick(10);
    chk("t2_fin", 32'(bus.finished_counting), 1);
    tick(300);
    drv(0, 0, 1);
    tick();
    chk("t2_res_sat", 32'(bus.result), 255);
    chk("t2_ovf", 32'(bus.overflow), 1);
    chk("t2_rv", 32'(bus.result_valid), 1);
    drv(1, 0, 0);
    tick();
    chk("t2_ovf_kept", 32'(bus.overflow), 1);
    drv(0, 1, 0);
    tick(30);
    drv(0, 0, 1);
    tick();
    chk("t2_res20", 32'(bus.result), 20);
    chk("t2_ovf0", 32'(bus.overflow), 0);
    drv(0, 0, 0);
    tick();

    // 3: clear mid-integrate
    drv(1, 0, 0);
    tick();
    drv(0, 1, 0);
    tick(5);
    drv(1, 1, 0);
    tick();
    chk("t3_fin_clr", 32'(bus.finished_counting), 0);
    drv(0, 1, 0);
    tick(9);
    chk("t3_fin9", 32'(bus.finished_counting), 0);
    tick();
    chk("t3_fin10", 32'(bus.finished_counting), 1);

    // 5: load during integrate
    drv(1, 0, 0);
    tick();
    drv(0, 1, 0);
    tick(4);
    drv(0, 1, 1);
    tick();
    chk("t5_err", 32'(bus.seq_error), 1);
    chk("t5_rv", 32'(bus.result_valid), 0);
    chk("t5_res", 32'(bus.result), 20);
    drv(0, 1, 0);
    tick(4);
    chk("t5_fin9", 32'(bus.finished_counting), 0);
    tick();
    chk("t5_fin10", 32'(bus.finished_counting), 1);
    drv(1, 0, 0);
    tick();
    chk("t5_err_clr", 32'(bus.seq_error), 0);

    // 6: enable gap
    drv(0, 1, 0);
    tick(4);
    drv(0, 0, 0);
    tick(3);
    drv(0, 1, 0);
    tick(5);
    chk("t6_fin12", 32'(bus.finished_counting), 0);
    tick();
    chk("t6_fin13", 32'(bus.finished_counting), 1);

    // 4: async reset mid-DEINT
    drv(1, 0, 0);
    tick();
    drv(0, 1, 0);
    tick(2);
    drv(0, 1, 1);
    tick();
    drv(0, 1, 0);
    tick(7);
    chk("t4_fin", 32'(bus.finished_counting), 1);
    chk("t4_err", 32'(bus.seq_error), 1);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_fin0", 32'(bus.finished_counting), 0);
    chk("t4_res0", 32'(bus.result), 0);
    chk("t4_err0", 32'(bus.seq_error), 0);
    chk("t4_ovf0", 32'(bus.overflow), 0);
    chk("t4_rv0", 32'(bus.result_valid), 0);
    drv(0, 0, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("t4_idle", 32'(bus.finished_counting), 0);
    drv(0, 1, 0);
    tick(9);
    chk("t4_fin9", 32'(bus.finished_counting), 0);
    tick();
    chk("t4_fin10", 32'(bus.finished_counting), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_slope_counter.md
# dual_slope_counter

Counter/result datapath of the dual-slope ADC; the responder to the converter's control sequencer. It counts the fixed integrate interval and reports completion on `finished_counting`. It then counts the de-integrate interval until the sequencer's `load`, and latches that count as the conversion result. Sits between the sequencer and the display/readout logic.

## Interface
- `WIDTH`, 12: counter and result width in bits.
- `N_INT`, 1000: integrate-phase length in enabled clock cycles; must satisfy 2 ≤ N_INT ≤ 2^WIDTH.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low system reset.
- `clear`  in  1  synchronous, active-high counter clear; driven by the sequencer's counter-reset output.
- `enable_counting`  in  1  count enable from the sequencer.
- `load`  in  1  one-cycle latch strobe from the sequencer.
- `finished_counting`  out  1  level; integrate interval complete.
- `result`  out  WIDTH  last latched de-integrate count.
- `result_valid`  out  1  one-cycle pulse when `result` is updated.
- `overflow`  out  1  latched with `result`; the de-integrate count saturated.
- `seq_error`  out  1  sticky; `load` was received outside DEINT.

## Operation
- States: IDLE, INTEGRATE, DEINT, DONE. Internal `count` is WIDTH bits.
- **IDLE**
  - `enable_counting`=1 → INTEGRATE.
  - `count` becomes 1 on that same edge; this edge is the first enabled cycle.
- **INTEGRATE**
  - Each edge with enable=1: `count`+1.
  - On the edge where `count`==N_INT-1 and enable=1: `count`←0, `finished_counting`←1, → DEINT.
  - Enable=0: `count` holds. Gaps extend the interval; they do not restart it.
- **DEINT**
  - Each edge with enable=1: `count`+1, saturating at 2^WIDTH-1.
  - An internal sticky `sat` flag sets when the count attempts to exceed 2^WIDTH-1.
  - `load`=1: `result`←`count`, `overflow`←`sat`, `result_valid`←1 for one cycle, → DONE.
  - `load` has priority over enable. The increment is suppressed on the load edge.
- **DONE**
  - Holds. `enable_counting` and `load` are ignored.
  - `finished_counting` stays 1 until `clear`.
- `load` in IDLE or INTEGRATE: `seq_error`←1. `result` and `overflow` are unchanged, no valid pulse, state unchanged.
- `clear`=1, any state:
  - → IDLE; `count`←0, `sat`←0, `finished_counting`←0, `seq_error`←0.
  - `result` and `overflow` are retained.
  - `clear` has priority over `load` and enable.
- `finished_counting` is a level, not a pulse, because the sequencer samples it on a later edge than the one where it advances phase.

## Timing
- Reset values: all outputs 0, `count`=0, `sat`=0, state IDLE.
- `rst_n` low takes effect immediately without a clock edge, at any point in a conversion.
- `finished_counting` rises on the N_INT-th enabled edge.
- `result` and `result_valid` are registered. Both are visible one cycle after the edge where `load` is sampled high.
- `result_valid` is high for exactly one cycle per accepted `load`.
- All inputs are synchronous to `clk`; no internal synchronizers.
- Simultaneous `clear`+`load` in DEINT: `clear` wins, no valid pulse.
- Simultaneous enable+`load` in DEINT: latch the pre-increment `count`.

## Structure
- Package `dual_slope_pkg`:
  - state enumeration typedef;
  - default `WIDTH`/`N_INT` constants, shared with the sequencer and readout.
- One sub-module, `sat_counter`:
  - WIDTH-bit enable/clear counter with saturation and a sticky saturate flag;
  - instantiated once, reused for both phases.
- Top FSM, terminal-count compare and result register live in `dual_slope_counter`.

## Test plan
(N_INT=10, WIDTH=8 unless stated)
1. Nominal conversion. Enable high 10 cycles → `finished_counting`=1 on the 10th edge. Then 37 enabled cycles, then `load` → `result`=37, `overflow`=0, `result_valid` high exactly 1 cycle.
2. Overflow. 300 enabled DEINT cycles then `load` → `result`=255, `overflow`=1. A following `clear` plus a 20-cycle conversion → `result`=20, `overflow`=0.
3. Clear mid-integrate. `clear` at `count`=5 → IDLE, `finished_counting`=0. The next conversion needs a full 10 enabled cycles before `finished_counting`.
4. Async reset. `rst_n` low mid-DEINT between clock edges → all outputs 0 before the next edge. Release → IDLE.
5. Protocol error. `load` during INTEGRATE at `count`=4 → `seq_error`=1, `result` unchanged, no valid pulse, counting continues. `clear` → `seq_error`=0.
6. Enable gap. Enable low 3 cycles after 4 integrate cycles → `count` holds at 4. `finished_counting` asserts 13 cycles after the first enable.
